yl3_rx_decoder: RTL

Receive-side decoder for the YL-3 dual-SN74HC595 serial link (DIO/SCK/RCK). It oversamples the three link pins on the system clock and reassembles 16-bit {position, segment} words. On each latch it updates an 8-digit segment image and its ASCII back-translation. It is used as the in-fabric monitor and scoreboard for the YL-3 driver, and to mirror the display onto debug outputs.

---
 rtl/yl3_rx_decoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/yl3_rx_decoder.sv
// Receive-side decoder for the YL-3 dual-595 serial link: oversamples DIO/SCK/RCK,
// rebuilds {pos, seg} words and maintains the segment and ASCII display images.
module yl3_rx_decoder #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        DIO,
  input  logic        SCK,
  input  logic        RCK,
  output logic [63:0] SEG_ARRAY,
  output logic [63:0] CHR_ARRAY,
  output logic [15:0] WORD,
  output logic        FRAME_VALID,
  output logic        FRAME_ERR,
  output logic        SCAN_DONE,
  output logic [15:0] FRAME_CNT
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned SEG_W  = 8;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WORD = CNT_W'(WORD_W);
  localparam logic [SEG_W-1:0] ASCII_SP = 8'h20;

  logic [SYNC_STAGES-1:0] dio_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] rck_sync;
  logic                   sck_prev;
  logic                   rck_prev;
  logic [WORD_W-1:0]      shift_reg;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DIGITS-1:0]      mask;

  logic              dio_bit_c;
  logic              sck_rise_c;
  logic              rck_rise_c;
  logic              pos_onehot_c;
  logic              accept_c;
  logic              reject_c;
  logic              scan_c;
  logic [DIGITS-1:0] pos_c;
  logic [DIGITS-1:0] mask_next_c;
  logic [SEG_W-1:0]  seg_c;
  logic [SEG_W-1:0]  chr_c;

  // Active-low .GFEDCBA pattern back to the character it displays.
  function automatic logic [SEG_W-1:0] seg_to_ascii(input logic [SEG_W-1:0] seg);
    case (seg)
      8'hC0:   return 8'h30;
      8'hF9:   return 8'h31;
      8'hA4:   return 8'h32;
      8'hB0:   return 8'h33;
      8'h99:   return 8'h34;
      8'h92:   return 8'h35;
      8'h82:   return 8'h36;
      8'hF8:   return 8'h37;
      8'h80:   return 8'h38;
      8'h98:   return 8'h39;
      8'h88:   return 8'h41;
      8'h83:   return 8'h62;
      8'hC6:   return 8'h43;
      8'hA1:   return 8'h64;
      8'h86:   return 8'h45;
      8'h8E:   return 8'h46;
      8'hFF:   return 8'h20;
      8'h7F:   return 8'h2E;
      default: return 8'h3F;
    endcase
  endfunction

  // Edge detection and frame evaluation on the pre-shift register contents.
  always_comb begin
    dio_bit_c    = dio_sync[SYNC_STAGES-1];
    sck_rise_c   = sck_sync[SYNC_STAGES-1] & ~sck_prev;
    rck_rise_c   = rck_sync[SYNC_STAGES-1] & ~rck_prev;
    pos_c        = shift_reg[WORD_W-1:SEG_W];
    seg_c        = shift_reg[SEG_W-1:0];
    chr_c        = seg_to_ascii(seg_c);
    pos_onehot_c = (pos_c != '0) && ((pos_c & (pos_c - DIGITS'(1))) == '0);
    accept_c     = rck_rise_c && (bit_cnt == CNT_WORD) && pos_onehot_c;
    reject_c     = rck_rise_c && !accept_c;
    mask_next_c  = mask | pos_c;
    scan_c       = accept_c && (mask_next_c == '1);
  end

  // Synchronizers plus one edge-detect flop; DIO shares the same depth as SCK.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      dio_sync <= '0;
      sck_sync <= '0;
      rck_sync <= '0;
      sck_prev <= 1'b0;
      rck_prev <= 1'b0;
    end else begin
      dio_sync <= {dio_sync[SYNC_STAGES-2:0], DIO};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], SCK};
      rck_sync <= {rck_sync[SYNC_STAGES-2:0], RCK};
      sck_prev <= sck_sync[SYNC_STAGES-1];
      rck_prev <= rck_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      shift_reg   <= '0;
      bit_cnt     <= '0;
      mask        <= '0;
      SEG_ARRAY   <= '1;
      CHR_ARRAY   <= {DIGITS{ASCII_SP}};
      WORD        <= '1;
      FRAME_CNT   <= '0;
      FRAME_VALID <= 1'b0;
      FRAME_ERR   <= 1'b0;
      SCAN_DONE   <= 1'b0;
    end else begin
      if (sck_rise_c) shift_reg <= {shift_reg[WORD_W-2:0], dio_bit_c};

      // A latch restarts the count; a coincident shift becomes bit 1 of the next word.
      if (rck_rise_c)                          bit_cnt <= sck_rise_c ? CNT_W'(1) : '0;
      else if (sck_rise_c && bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + CNT_W'(1);

      FRAME_VALID <= accept_c;
      FRAME_ERR   <= reject_c;
      SCAN_DONE   <= scan_c;

      if (accept_c) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (pos_c[i]) begin
            SEG_ARRAY[SEG_W*(DIGITS-1-i) +: SEG_W] <= seg_c;
            CHR_ARRAY[SEG_W*(DIGITS-1-i) +: SEG_W] <= chr_c;
          end
        end
        WORD      <= shift_reg;
        FRAME_CNT <= FRAME_CNT + 16'd1;
        mask      <= scan_c ? '0 : mask_next_c;
      end
    end
  end

endmodule
